mux41_rr_arbiter: RTL and testbench

MUX41_RR_ARBITER -- requirements
Module: mux41_rr_arbiter

---
 rtl/mux41_rr_arbiter_pkg.sv | 22 ++
 rtl/mux41_rr_arbiter_pick.sv | 34 +++
 rtl/mux41_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mux41_rr_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mux41_rr_arbiter_pkg.sv
// mux41_rr_arbiter_pkg
// Shared types and constants for the 4:1 round-robin arbitrated mux.
//   state_t          : arbiter FSM states (IDLE, GRANT)
//   idx_t            : 2-bit requester index
//   DEFAULT_MAX_HOLD : default grant-hold limit
//   onehot4()        : index -> one-hot 4-bit grant vector
package mux41_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef logic [1:0] idx_t;

  localparam int DEFAULT_MAX_HOLD = 4;

  function automatic logic [3:0] onehot4(input idx_t idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux41_rr_arbiter_pick.sv
// rr_pick4
// Combinational circular priority search over four request bits.
// Ports:
//   req [3:0] : request vector, bit i belongs to requester i
//   ptr [1:0] : index the search starts from (highest priority)
//   any       : at least one request bit is set
//   idx [1:0] : first set request bit at or after ptr, wrapping 3 -> 0
module rr_pick4
  import mux41_rr_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  idx_t       ptr,
  output logic       any,
  output idx_t       idx
);

  idx_t cand;

  // Walk the offsets from farthest to nearest so the nearest set bit
  // (lowest offset from ptr) is the last one written and wins.
  always_comb begin
    idx  = ptr;
    cand = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + idx_t'(i);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux41_rr_arbiter.sv
// mux41_rr_arbiter
// Four-requester round-robin arbiter driving a registered 4:1 data mux.
// A requester keeps the grant while it holds req, but gives it up after
// MAX_HOLD cycles when someone else is waiting. Release and regrant happen
// on the same edge, so a busy arbiter never shows an idle gap.
// Parameters:
//   WIDTH    : data width per requester
//   MAX_HOLD : consecutive grant cycles allowed while others wait (1..15)
// Ports:
//   clk            : rising-edge clock
//   rst            : asynchronous active-high reset
//   req [3:0]      : request per requester
//   in0..in3       : requester data
//   gnt [3:0]      : registered one-hot grant, zero when idle
//   s0, s1         : registered mux select, {s1,s0} = granted index
//   out            : registered data selected by the current {s1,s0}
//   out_valid      : out carries data from a still-requesting grantee
module mux41_rr_arbiter
  import mux41_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       gnt,
  output logic             s0,
  output logic             s1,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [3:0] HOLD_MAX  = 4'(MAX_HOLD);

  state_t           state, state_nxt;
  logic [3:0]       gnt_nxt;
  idx_t             sel, sel_nxt;
  idx_t             ptr, ptr_nxt;
  logic [3:0]       hold_cnt, hold_nxt;

  idx_t             pick_ptr;
  logic             pick_any;
  idx_t             pick_idx;
  logic             held;
  logic             others;
  logic             at_limit;
  logic             release_now;
  logic [WIDTH-1:0] mux_data;

  // While granting, the search starts just past the current owner: that
  // is the pointer value a release would leave behind, so a same-edge
  // regrant already sees the updated priority.
  assign pick_ptr = (state == GRANT) ? idx_t'(sel + idx_t'(1)) : ptr;

  rr_pick4 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign held        = req[sel];
  assign others      = |(req & ~onehot4(sel));
  assign at_limit    = (hold_cnt == HOLD_LAST);
  // A dropped request and an expired hold limit on the same cycle collapse
  // into one release; there is only one pointer advance either way.
  assign release_now = !held || (at_limit && others);

  // Next-state and next-grant logic.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    unique case (state)
      IDLE: begin
        gnt_nxt  = '0;
        hold_nxt = '0;
        if (pick_any) begin
          state_nxt = GRANT;
          sel_nxt   = pick_idx;
          gnt_nxt   = onehot4(pick_idx);
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_nxt  = idx_t'(sel + idx_t'(1));
          hold_nxt = '0;
          if (others) begin
            sel_nxt = pick_idx;
            gnt_nxt = onehot4(pick_idx);
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end else if (at_limit) begin
          // Nobody else is waiting: keep the grant and start a new window.
          hold_nxt = '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        hold_nxt  = '0;
      end
    endcase
  end

  // FSM and arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    mux_data = in0;
    unique case (sel)
      2'd0: mux_data = in0;
      2'd1: mux_data = in1;
      2'd2: mux_data = in2;
      2'd3: mux_data = in3;
      default: mux_data = in0;
    endcase
  end

  // Data path follows the select that is already registered, so data
  // appears one cycle after the grant that chose it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= mux_data;
      out_valid <= (state == GRANT) && held;
    end
  end

  assign s0 = sel[0];
  assign s1 = sel[1];

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// tb_mux41_rr_arbiter
// Scoreboard bench for mux41_rr_arbiter. Each driven cycle runs a
// behavioural arbiter model and queues the expected registered outputs;
// a monitor process compares them after every rising edge.
module tb_mux41_rr_arbiter;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out;
    logic             ov;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic [3:0]       gnt;
  logic             s0, s1;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Model state: owner index (-1 when idle), last select, pointer, hold.
  int m_cur, m_sel, m_ptr, m_hold;

  mux41_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .gnt       (gnt),
    .s0        (s0),
    .s1        (s1),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  function automatic int firstFrom(input logic [3:0] r, input int p);
    for (int d = 0; d < 4; d++) begin
      if (r[(p + d) % 4]) return (p + d) % 4;
    end
    return -1;
  endfunction

  function automatic void modelReset();
    m_cur  = -1;
    m_sel  = 0;
    m_ptr  = 0;
    m_hold = 0;
  endfunction

  // Called at a falling edge: drives the inputs, advances the model by one
  // rising edge, queues the expectation, then waits for the next fall.
  task automatic applyStimulus(input logic [3:0] r, input logic [WIDTH-1:0] d0,
                               input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                               input logic [WIDTH-1:0] d3);
    logic [WIDTH-1:0] d [4];
    exp_t e;
    bit   others, lim;
    req = r; in0 = d0; in1 = d1; in2 = d2; in3 = d3;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    e.out = d[m_sel];
    e.ov  = (m_cur >= 0) && r[m_cur];
    if (m_cur < 0) begin
      if (r != 4'b0) begin
        m_cur  = firstFrom(r, m_ptr);
        m_sel  = m_cur;
        m_hold = 0;
      end
    end else begin
      others = (r & ~(4'b0001 << m_cur)) != 4'b0;
      lim    = (m_hold == MAX_HOLD - 1);
      if (!r[m_cur] || (lim && others)) begin
        m_ptr  = (m_cur + 1) % 4;
        m_hold = 0;
        if (others) begin
          m_cur = firstFrom(r, m_ptr);
          m_sel = m_cur;
        end else begin
          m_cur = -1;
        end
      end else if (lim) begin
        m_hold = 0;
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
    end
    e.gnt = (m_cur < 0) ? 4'b0 : 4'(4'b0001 << m_cur);
    e.sel = 2'(m_sel);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Asserts reset between edges with the current req still applied and
  // checks that the outputs clear without waiting for a clock.
  task automatic doReset(input logic [3:0] r);
    req = r;
    #2 rst = 1'b1;
    exp_q.delete();
    modelReset();
    #1;
    checkOutput("async_gnt", int'(gnt), 0);
    checkOutput("async_sel", int'({s1, s0}), 0);
    checkOutput("async_out", int'(out), 0);
    checkOutput("async_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: one queued expectation per rising edge outside reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("gnt", int'(gnt), int'(e.gnt));
        checkOutput("gnt_onehot0", int'($onehot0(gnt)), 1);
        checkOutput("sel", int'({s1, s0}), int'(e.sel));
        checkOutput("out", int'(out), int'(e.out));
        checkOutput("out_valid", int'(out_valid), int'(e.ov));
      end
    end
  end

  initial begin
    logic [3:0] r;
    rst = 1'b1;
    req = '0; in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    modelReset();
    @(negedge clk);
    rst = 1'b0;

    // Reset with every requester asking; first grant must go to 0.
    doReset(4'b1111);
    applyStimulus(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4);
    applyStimulus(4'b1111, 4'h1, 4'h2, 4'h3, 4'h4);

    // Lone requester 2 keeps its grant well beyond the hold limit.
    doReset(4'b0000);
    for (int i = 0; i < 3 * MAX_HOLD; i++) applyStimulus(4'b0100, 4'h0, 4'h0, 4'h1, 4'h0);

    // Full load: strict rotation with no idle gaps.
    doReset(4'b0000);
    for (int i = 0; i < 5 * MAX_HOLD + 2; i++) applyStimulus(4'b1111, 4'h5, 4'h6, 4'h7, 4'h8);

    // Early release from 1 while 0 and 3 wait: search resumes at 2.
    doReset(4'b0000);
    applyStimulus(4'b0010, 4'h0, 4'hA, 4'h0, 4'h0);
    applyStimulus(4'b0010, 4'h0, 4'hA, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1001, 4'hB, 4'h0, 4'h0, 4'hC);

    // Owner 3 drops at its hold limit while 0 asks: one release, wrap to 0.
    doReset(4'b0000);
    for (int i = 0; i < MAX_HOLD; i++) applyStimulus(4'b1000, 4'h0, 4'h0, 4'h0, 4'hD);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0001, 4'hE, 4'h0, 4'h0, 4'h0);

    // Reset in the middle of a grant to 2, then restart from pointer 0.
    doReset(4'b0000);
    applyStimulus(4'b0100, 4'h0, 4'h0, 4'h9, 4'h0);
    applyStimulus(4'b0100, 4'h0, 4'h0, 4'h9, 4'h0);
    doReset(4'b0100);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0110, 4'h0, 4'h3, 4'h9, 4'h0);

    // Randomized traffic with sticky requests and occasional resets.
    for (int seg = 0; seg < 5; seg++) begin
      doReset(4'($urandom_range(0, 15)));
      r = 4'($urandom_range(0, 15));
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        applyStimulus(r, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
      end
    end

    @(posedge clk);
    #2;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
